// File: rtl/fetch_bundle_gen_if.sv
// I-cache request/response channel between the fetch bundle
// generator (master) and the instruction cache (slave).
interface fetch_bundle_gen_if;
    logic         icache_req_o;
    logic [63:0]  icache_addr_o;
    logic         icache_gnt_i;
    logic         icache_rsp_vld_i;
    logic [255:0] icache_rsp_data_i;

    modport master (
        output icache_req_o,
        output icache_addr_o,
        input  icache_gnt_i,
        input  icache_rsp_vld_i,
        input  icache_rsp_data_i
    );

    modport slave (
        input  icache_req_o,
        input  icache_addr_o,
        output icache_gnt_i,
        output icache_rsp_vld_i,
        output icache_rsp_data_i
    );
endinterface

// File: rtl/fetch_bundle_gen.sv
// Sequential 32-byte block fetcher producing 8-lane instruction
// bundles with lane masking, full-buffer hold and flush/redirect.
module fetch_bundle_gen #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  logic [63:0]              redirect_pc_i,
    fetch_bundle_gen_if.master       ic,
    input  logic                     buf_full_i,
    output logic [31:0]              inst0_o,
    output logic [31:0]              inst1_o,
    output logic [31:0]              inst2_o,
    output logic [31:0]              inst3_o,
    output logic [31:0]              inst4_o,
    output logic [31:0]              inst5_o,
    output logic [31:0]              inst6_o,
    output logic [31:0]              inst7_o,
    output logic                     inst0_vld_o,
    output logic                     inst1_vld_o,
    output logic                     inst2_vld_o,
    output logic                     inst3_vld_o,
    output logic                     inst4_vld_o,
    output logic                     inst5_vld_o,
    output logic                     inst6_vld_o,
    output logic                     inst7_vld_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         kill_q;
    logic         kill_d;
    logic [63:2]  fetch_pc_q;
    logic [63:2]  pc_next;
    logic [7:0]   lane_mask;
    logic [255:0] hold_data_q;
    logic [7:0]   hold_mask_q;
    logic [255:0] out_data_q;
    logic [7:0]   out_mask_q;

    logic rsp;
    logic take;
    logic emit_rsp;
    logic cap;
    logic emit_hold;
    logic flush_to_wait;
    logic unused_bits;

    // Low PC bits select a byte within an instruction; never used.
    assign unused_bits = ^{redirect_pc_i[1:0]};

    assign rsp       = ic.icache_rsp_vld_i;
    assign lane_mask = 8'hFF << fetch_pc_q[4:2];
    assign pc_next   = {fetch_pc_q[63:5] + 59'd1, 3'b000};

    // A response is consumed only when neither stale nor flushed.
    assign take      = (state_q == WAIT) && rsp && !kill_q && !flush_i;
    assign emit_rsp  = take && !buf_full_i;
    assign cap       = take && buf_full_i;
    assign emit_hold = (state_q == HOLD) && !buf_full_i && !flush_i;

    // Flush keeps us waiting when a grant is (or was) already out.
    assign flush_to_wait = ((state_q == REQ) && ic.icache_gnt_i) ||
                           ((state_q == WAIT) && !rsp);

    // State and kill registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    // Next-state and kill decision; flush overrides everything.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (ic.icache_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (rsp) begin
                    kill_d  = 1'b0;
                    state_d = (kill_q || !buf_full_i) ? REQ : HOLD;
                end
            end
            HOLD: begin
                if (!buf_full_i) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = flush_to_wait ? WAIT : REQ;
            kill_d  = flush_to_wait;
        end
    end

    // Request is asserted exactly while in REQ.
    always_comb begin
        ic.icache_req_o  = (state_q == REQ);
        ic.icache_addr_o = {fetch_pc_q[63:5], 5'b0};
    end

    // Fetch PC: redirect on flush, step one block per consumed response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC[63:2];
        end else if (flush_i) begin
            fetch_pc_q <= redirect_pc_i[63:2];
        end else if (take) begin
            fetch_pc_q <= pc_next;
        end
    end

    // Hold buffer for a bundle that arrived while the buffer was full.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_data_q <= '0;
            hold_mask_q <= '0;
        end else if (flush_i) begin
            hold_mask_q <= '0;
        end else if (cap) begin
            hold_data_q <= ic.icache_rsp_data_i;
            hold_mask_q <= lane_mask;
        end
    end

    // Registered bundle outputs; the mask is a one-cycle pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q <= '0;
            out_mask_q <= '0;
        end else if (emit_rsp) begin
            out_data_q <= ic.icache_rsp_data_i;
            out_mask_q <= lane_mask;
        end else if (emit_hold) begin
            out_data_q <= hold_data_q;
            out_mask_q <= hold_mask_q;
        end else begin
            out_mask_q <= '0;
        end
    end

    assign inst0_o = out_data_q[31:0];
    assign inst1_o = out_data_q[63:32];
    assign inst2_o = out_data_q[95:64];
    assign inst3_o = out_data_q[127:96];
    assign inst4_o = out_data_q[159:128];
    assign inst5_o = out_data_q[191:160];
    assign inst6_o = out_data_q[223:192];
    assign inst7_o = out_data_q[255:224];

    assign inst0_vld_o = out_mask_q[0];
    assign inst1_vld_o = out_mask_q[1];
    assign inst2_vld_o = out_mask_q[2];
    assign inst3_vld_o = out_mask_q[3];
    assign inst4_vld_o = out_mask_q[4];
    assign inst5_vld_o = out_mask_q[5];
    assign inst6_vld_o = out_mask_q[6];
    assign inst7_vld_o = out_mask_q[7];

endmodule

// File: doc/fetch_bundle_gen.md
# fetch_bundle_gen

Front-end bundle producer feeding the decode instruction buffer. It fetches 32-byte aligned I-cache blocks sequentially from a PC and presents each block as an 8-instruction bundle with per-lane valid bits. It masks lanes that precede an unaligned fetch PC, holds a bundle while the buffer reports full, and discards in-flight fetches on flush before restarting at the redirect PC.

## Interface
Parameters:
- RESET_PC, 64'h0, first fetch address after reset (bits [1:0] ignored)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush/redirect request, one cycle
- redirect_pc_i  in  64  new fetch PC, sampled when flush_i=1
- icache_req_o  out  1  fetch request; held until granted
- icache_addr_o  out  64  request address, {pc[63:5],5'b0}, stable while req pending
- icache_gnt_i  in  1  request accepted this cycle
- icache_rsp_vld_i  in  1  response data valid (exactly one per grant, ≥1 cycle after gnt)
- icache_rsp_data_i  in  256  8 instructions, lane n = bits [32n+31:32n]
- buf_full_i  in  1  instruction buffer cannot take a bundle
- inst0_o..inst7_o  out  32 each  bundle lanes 0..7
- inst0_vld_o..inst7_vld_o  out  1 each  lane valid; all 0 when no bundle is issued

## Operation
- State machine states: IDLE, REQ, WAIT, HOLD. Internal registers: fetch_pc[63:2], kill, hold_data[255:0], hold_mask[7:0].
- IDLE: entered only on reset. Next cycle → REQ with fetch_pc=RESET_PC.
- REQ: icache_req_o=1. On icache_gnt_i → WAIT.
- WAIT: wait for icache_rsp_vld_i. On response:
  - if kill=1: drop the data, clear kill → REQ.
  - else if buf_full_i=0: drive the bundle next cycle, advance fetch_pc → REQ.
  - else: capture data and mask in the hold registers, advance fetch_pc → HOLD.
- HOLD: when buf_full_i=0, drive the held bundle next cycle → REQ.
- Lane mask = 8'hFF << fetch_pc[4:2]. Lanes below the PC offset are invalid.
- Next PC = {fetch_pc[63:5]+1, 3'b000}. Wrap at 2^64 is a modulo add, with no special handling.
- Valid outputs are registered and are single-cycle pulses, one pulse per bundle. The vld bits are 0 in every other cycle. inst*_o data is don't-care when its vld bit is 0.
- Flush (highest priority; takes effect the same cycle):
  - fetch_pc←redirect_pc_i. Next-cycle vld outputs are all 0.
  - Hold contents are discarded.
  - IDLE/REQ without gnt → REQ; the address updates the next cycle.
  - REQ with gnt in the same cycle → WAIT, kill=1.
  - WAIT without rsp → WAIT, kill=1.
  - WAIT with rsp in the same cycle → REQ; the response is dropped and kill stays 0.
  - HOLD → REQ.
- At most one outstanding I-cache request.

## Timing
- Reset values: icache_req_o=0, icache_addr_o={RESET_PC[63:5],5'b0}, all inst*_vld_o=0, inst*_o=0, state IDLE, kill=0.
- First request: icache_req_o=1 in the second cycle after reset deassertion.
- Latency: response in cycle T → bundle on the outputs in cycle T+1, or later if full. REQ (icache_req_o=1) also begins in cycle T+1.
- Full held for N cycles after the response: the bundle appears in the cycle after the first cycle where buf_full_i=0.
- buf_full_i is only consulted at response/HOLD decisions. A bundle already registered is always delivered.
- Flush in cycle F: no valid bundle in F+1. The new request with redirect_pc is issued at F+1, or after the killed response returns.

## Test plan
- Reset, RESET_PC=0x1000, 2-cycle I-cache, buf_full_i=0 → requests to 0x1000, 0x1020, 0x1040; each bundle has vld=8'hFF, lane data matches rsp_data, and pulses are 1 cycle each.
- Flush with redirect_pc=0x2014, then respond → first bundle has vld=8'b11100000 (lanes 5-7) with the address at 0x2000; the next request is 0x2020 with vld=8'hFF.
- Hold buf_full_i=1 across the response for 5 cycles → no vld and no new request while full; the bundle appears exactly 1 cycle after full drops, then the request to the next PC follows.
- Flush in WAIT, then the stale response arrives → the stale data never appears on the outputs, and the next request is the redirect PC.
- Flush in the same cycle as icache_rsp_vld_i and again in the same cycle as icache_gnt_i → in both cases no stale bundle is emitted. Only one request is outstanding at a time, and it is to the redirect PC.
- Assert reset_n low mid-WAIT and mid-HOLD → all outputs return to their reset values immediately; the sequence restarts from RESET_PC and late responses are ignored.
